// File: rtl/cell_pos_reader.sv
// Read-side master for one cell position RAM: fetches the particle count from word 0,
// then streams words 1..count through a credit-limited skid FIFO. Optional macro: CELL_READ_CLAMP_EN.
module cell_pos_reader #(
    parameter int DATA_WIDTH   = 96,
    parameter int PARTICLE_NUM = 220,
    parameter int ADDR_WIDTH   = 8,
    parameter int RD_LATENCY   = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] particle_count,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_rden,
    output logic                  mem_wren,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int WAIT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [ADDR_WIDTH-1:0] COUNT_MAX = ADDR_WIDTH'(PARTICLE_NUM - 1);
`ifdef CELL_READ_CLAMP_EN
    localparam bit CLAMP_EN = 1'b1;
`else
    localparam bit CLAMP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_REQ,
        S_CNT_WAIT,
        S_STREAM,
        S_DRAIN
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]   count_q, count_d;
    logic                    done_q, done_d;
    logic [WAIT_W-1:0]       wait_q, wait_d;
    logic [CNT_W-1:0]        inflight_q, inflight_d;
    logic [CNT_W-1:0]        occ_q, occ_d;
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic                    pipe_vld_q  [RD_LATENCY];
    logic                    pipe_last_q [RD_LATENCY];
    logic [DATA_WIDTH-1:0]   fifo_data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]   fifo_last_q;

    logic                    start_ok;
    logic                    credit_ok;
    logic [CNT_W:0]          credit_sum;
    logic                    issue;
    logic                    issue_last;
    logic                    push;
    logic                    pop;
    logic                    ret_last;
    logic [ADDR_WIDTH-1:0]   count_raw;
    logic [ADDR_WIDTH-1:0]   count_lat;

    assign count_raw  = mem_q[ADDR_WIDTH-1:0];
    assign count_lat  = (CLAMP_EN && (count_raw > COUNT_MAX)) ? COUNT_MAX : count_raw;

    // A start coinciding with the done pulse is dropped so a new run never overlaps the old one.
    assign start_ok   = start && (state_q == S_IDLE) && !done_q;
    assign credit_sum = {1'b0, occ_q} + {1'b0, inflight_q};
    assign credit_ok  = credit_sum < (CNT_W + 1)'(FIFO_DEPTH);
    assign issue      = (state_q == S_STREAM) && credit_ok;
    assign issue_last = (addr_q == count_q);
    assign push       = pipe_vld_q[RD_LATENCY-1];
    assign ret_last   = pipe_last_q[RD_LATENCY-1];
    assign pop        = out_valid && out_ready;

    assign busy           = (state_q != S_IDLE);
    assign done           = done_q;
    assign particle_count = count_q;
    assign mem_address    = addr_q;
    assign mem_rden       = (state_q == S_CNT_REQ) || issue;
    assign mem_wren       = 1'b0;
    assign mem_data       = '0;
    assign out_valid      = (occ_q != '0);
    assign out_data       = fifo_data_q[rd_ptr_q];
    assign out_last       = fifo_last_q[rd_ptr_q];

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        count_d    = count_q;
        done_d     = 1'b0;
        wait_d     = wait_q;
        inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(push);
        occ_d      = occ_q + CNT_W'(push) - CNT_W'(pop);
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_CNT_REQ;
                    addr_d  = '0;
                end
            end
            S_CNT_REQ: begin
                state_d = S_CNT_WAIT;
                wait_d  = '0;
            end
            S_CNT_WAIT: begin
                if (wait_q == WAIT_W'(RD_LATENCY - 1)) begin
                    count_d = count_lat;
                    if (count_lat == '0) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        addr_d  = ADDR_WIDTH'(1);
                        state_d = S_STREAM;
                    end
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_STREAM: begin
                if (issue) begin
                    if (issue_last) begin
                        state_d = S_DRAIN;
                    end else begin
                        addr_d = addr_q + ADDR_WIDTH'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (pop && out_last) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            count_q    <= '0;
            done_q     <= 1'b0;
            wait_q     <= '0;
            inflight_q <= '0;
            occ_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            done_q     <= done_d;
            wait_q     <= wait_d;
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
        end
    end

    // Issue tags ride alongside the RAM latency so each return knows whether it is a particle and the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_vld_q[i]  <= 1'b0;
                pipe_last_q[i] <= 1'b0;
            end
        end else begin
            pipe_vld_q[0]  <= issue;
            pipe_last_q[0] <= issue && issue_last;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_last_q[i] <= pipe_last_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
            end
            fifo_last_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            if (push) begin
                fifo_data_q[wr_ptr_q] <= mem_q;
                fifo_last_q[wr_ptr_q] <= ret_last;
                wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cell_pos_reader.sv
// Scoreboard bench for cell_pos_reader: a RAM model feeds the DUT, directed runs push the expected
// beats into a queue and a negedge monitor pops and compares every accepted beat.
module tb_cell_pos_reader;

    localparam int DW = 96;
    localparam int PN = 220;
    localparam int AW = 8;
    localparam int RL = 1;
    localparam int FD = 4;
`ifdef CELL_READ_CLAMP_EN
    localparam int T6_N = PN - 1;
`else
    localparam int T6_N = 250;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic [AW-1:0] particle_count;
    logic [AW-1:0] mem_address;
    logic          mem_rden;
    logic          mem_wren;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] mem_q = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          out_last;

    always #5 clk = ~clk;

    cell_pos_reader #(
        .DATA_WIDTH  (DW),
        .PARTICLE_NUM(PN),
        .ADDR_WIDTH  (AW),
        .RD_LATENCY  (RL),
        .FIFO_DEPTH  (FD)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .particle_count(particle_count),
        .mem_address   (mem_address),
        .mem_rden      (mem_rden),
        .mem_wren      (mem_wren),
        .mem_data      (mem_data),
        .mem_q         (mem_q),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_last      (out_last)
    );

    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_rden) mem_q <= ram[mem_address];
    end

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int start_cyc = 0;
    int accepted = 0;
    int issued = 0;
    int max_out = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int last_beat_cyc = -1;
    int first_valid = -1;
    int rdy_mode = 0;
    int rdy_cnt = 0;
    bit hold_pending = 1'b0;
    logic [DW:0] held = '0;
    logic [DW:0] exp_q [$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pos_word(input int k, input int tag);
        logic [31:0] z, y, x;
        z = 32'(tag * 1000 + k);
        y = 32'(k * 7 + 3);
        x = 32'hC0DE_0000 ^ 32'(k);
        return {z, y, x};
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            1: out_ready = !out_ready;
            2: begin
                out_ready = (rdy_cnt >= 10);
                rdy_cnt++;
            end
            default: out_ready = 1'b1;
        endcase
    end

    // Monitor: decoupled from stimulus, compares every accepted beat against the queue head.
    always @(negedge clk) begin
        logic [DW:0] e;
        if (!rst_n) begin
            hold_pending = 1'b0;
        end else begin
            if (mem_rden && mem_address != '0) begin
                issued++;
                if (issued - accepted > max_out) max_out = issued - accepted;
            end
            if (hold_pending) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_beat", {out_last, out_data}, held);
            end
            hold_pending = out_valid && !out_ready;
            held = {out_last, out_data};
            if (out_valid && first_valid < 0) first_valid = cyc - start_cyc;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", out_data, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", out_data, e[DW-1:0]);
                    chk("beat_last", out_last, e[DW]);
                end
                accepted++;
                if (out_last) last_beat_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic load(input int cnt_word, input int n_exp, input int tag, input int mode);
        for (int k = 0; k < (1 << AW); k++) ram[k] = pos_word(k, tag);
        ram[0] = DW'(cnt_word);
        for (int k = 1; k <= n_exp; k++) exp_q.push_back({(k == n_exp), pos_word(k, tag)});
        accepted = 0;
        issued = 0;
        max_out = 0;
        done_cnt = 0;
        done_cyc = -1;
        last_beat_cyc = -1;
        first_valid = -1;
        rdy_cnt = 0;
        rdy_mode = mode;
    endtask

    task automatic run_test(input string nm, input int cnt_word, input int n_exp, input int tag,
                            input int mode, input int restart_at, input bit start_on_done);
        bit got;
        got = 1'b0;
        load(cnt_word, n_exp, tag, mode);
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                got = 1'b1;
                break;
            end
            start = (i == restart_at);
        end
        chk({nm, "_done_seen"}, got, 1);
        if (start_on_done && got) begin
            start = 1'b1;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk({nm, "_done_count"}, done_cnt, 1);
        chk({nm, "_beats_left"}, exp_q.size(), 0);
        chk({nm, "_count"}, particle_count, n_exp);
        chk({nm, "_busy_after"}, busy, 0);
        if (n_exp > 0) chk({nm, "_done_timing"}, done_cyc, last_beat_cyc + 1);
        else begin
            chk({nm, "_done_timing"}, done_cyc - start_cyc, 3);
            chk({nm, "_no_valid"}, first_valid, -1);
        end
        $display("%s: count_word=%0d beats=%0d done_cycle=%0d", nm, cnt_word, accepted, done_cyc - start_cyc);
        exp_q.delete();
        rdy_mode = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        bit got;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_rden", mem_rden, 0);
        chk("rst_wren", mem_wren, 0);
        chk("rst_addr", mem_address, 0);
        chk("rst_count", particle_count, 0);
        chk("rst_last", out_last, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_mem_data", mem_data, 0);

        run_test("T1", 3, 3, 1, 0, -1, 1'b0);
        chk("T1_first_valid", first_valid, 5);
        run_test("T2", 0, 0, 2, 0, -1, 1'b1);
        run_test("T3a", 8, 8, 3, 1, -1, 1'b0);
        run_test("T3b", 8, 8, 4, 2, -1, 1'b0);
        chk("T3b_credit_max", max_out, FD);
        run_test("T4", 5, 5, 7, 0, 4, 1'b0);

        // Abort mid-stream: reset while the third beat is presented, then replay from particle 1.
        got = 1'b0;
        load(6, 6, 5, 0);
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (accepted >= 2) begin
                got = 1'b1;
                break;
            end
        end
        chk("T5_two_beats", got, 1);
        chk("T5_third_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("T5_rst_valid", out_valid, 0);
        chk("T5_rst_busy", busy, 0);
        chk("T5_rst_rden", mem_rden, 0);
        chk("T5_rst_data", out_data, 0);
        chk("T5_rst_count", particle_count, 0);
        chk("T5_rst_done", done, 0);
        $display("T5a: reset after %0d beats", accepted);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_test("T5b", 6, 6, 6, 0, -1, 1'b0);

        run_test("T6", 250, T6_N, 8, 0, -1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
